f3_ram_ctrl: RTL and testbench

- Sequencer for the layer-3 feature-map buffer: six parallel 16-bit maps, each 14x14 = 196 words, one write port and one read port, 1-cycle registered read latency.
- Owns the write address while the pooling stage fills the buffer.
- When the buffer is full, generates the 5x5 sliding-window read sequence for the following convolution stage.
- Tags returned data with window framing flags, then re-arms for the next image.
- Read data and write data do not pass through this block; only control and addresses do.

---
 rtl/f3_ram_ctrl_if.sv | 29 ++
 rtl/f3_ram_ctrl.sv | 149 ++++++++++++++
 tb/tb_f3_ram_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/f3_ram_ctrl_if.sv
// Control/address bundle between the layer-3 buffer sequencer and its neighbours.
// The sequencer takes the slave side; the pooling/convolution side takes the master side.
interface f3_ram_ctrl_if #(
  parameter int AW = 8
);
  logic          pool_valid;
  logic          f3_wr_en;
  logic [AW-1:0] f3_waddr;
  logic          conv_ready;
  logic [AW-1:0] f3_raddr;
  logic          rd_valid;
  logic          win_first;
  logic          win_last;
  logic          f3_busy;
  logic          f3_done;
  logic          ovf_err;

  modport slave (
    input  pool_valid, conv_ready,
    output f3_wr_en, f3_waddr, f3_raddr, rd_valid, win_first, win_last,
           f3_busy, f3_done, ovf_err
  );

  modport master (
    output pool_valid, conv_ready,
    input  f3_wr_en, f3_waddr, f3_raddr, rd_valid, win_first, win_last,
           f3_busy, f3_done, ovf_err
  );
endinterface

// File: rtl/f3_ram_ctrl.sv
// Layer-3 feature-map buffer sequencer: owns the write address during fill,
// then walks the KxK sliding-window read order and tags returned data.
module f3_ram_ctrl #(
  parameter int MAP_W = 14,
  parameter int K     = 5,
  parameter int AW    = 8
) (
  input logic        clk,
  input logic        rst,
  f3_ram_ctrl_if.slave bus
);
  localparam int OUT_W = MAP_W - K + 1;
  localparam int DEPTH = MAP_W * MAP_W;
  localparam int CW    = $clog2(OUT_W);
  localparam int KW    = $clog2(K);

  localparam logic [AW-1:0] LAST_WADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(MAP_W);
  localparam logic [AW-1:0] WROW_STEP  = AW'(MAP_W - OUT_W + 1);
  localparam logic [KW-1:0] K_MAX      = KW'(K - 1);
  localparam logic [CW-1:0] O_MAX      = CW'(OUT_W - 1);

  typedef enum logic [1:0] {FILL, SCAN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] rowBase_q, rowBase_d;
  logic [AW-1:0] winBase_q, winBase_d;
  logic [CW-1:0] oy_q, oy_d, ox_q, ox_d;
  logic [KW-1:0] ky_q, ky_d, kx_q, kx_d;
  logic          rdValid_q, winFirst_q, winLast_q, ovf_q;
  logic          issue;

  assign issue = (state_q == SCAN) && bus.conv_ready;

  // winBase tracks the window's top-left address and rowBase the start of the
  // current kernel row, so every step of the walk is an add of a small constant.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    raddr_d   = raddr_q;
    rowBase_d = rowBase_q;
    winBase_d = winBase_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    case (state_q)
      FILL: begin
        if (bus.pool_valid) begin
          if (wcnt_q == LAST_WADDR) begin
            wcnt_d  = '0;
            state_d = SCAN;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      SCAN: begin
        if (issue) begin
          if (kx_q != K_MAX) begin
            kx_d    = kx_q + 1'b1;
            raddr_d = raddr_q + 1'b1;
          end else begin
            kx_d = '0;
            if (ky_q != K_MAX) begin
              ky_d      = ky_q + 1'b1;
              rowBase_d = rowBase_q + ROW_STEP;
              raddr_d   = rowBase_q + ROW_STEP;
            end else begin
              ky_d = '0;
              if (ox_q != O_MAX) begin
                ox_d      = ox_q + 1'b1;
                winBase_d = winBase_q + 1'b1;
                rowBase_d = winBase_q + 1'b1;
                raddr_d   = winBase_q + 1'b1;
              end else begin
                ox_d = '0;
                if (oy_q != O_MAX) begin
                  oy_d      = oy_q + 1'b1;
                  winBase_d = winBase_q + WROW_STEP;
                  rowBase_d = winBase_q + WROW_STEP;
                  raddr_d   = winBase_q + WROW_STEP;
                end else begin
                  oy_d      = '0;
                  winBase_d = '0;
                  rowBase_d = '0;
                  raddr_d   = '0;
                  state_d   = DRAIN;
                end
              end
            end
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE: begin
        state_d = FILL;
        wcnt_d  = '0;
      end
      default: state_d = FILL;
    endcase
  end

  // Framing flags are captured with the issue so they line up with the data
  // the buffer returns one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      raddr_q    <= '0;
      rowBase_q  <= '0;
      winBase_q  <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      rdValid_q  <= 1'b0;
      winFirst_q <= 1'b0;
      winLast_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      raddr_q    <= raddr_d;
      rowBase_q  <= rowBase_d;
      winBase_q  <= winBase_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      rdValid_q  <= issue;
      winFirst_q <= issue && (ky_q == '0) && (kx_q == '0);
      winLast_q  <= issue && (ky_q == K_MAX) && (kx_q == K_MAX);
      ovf_q      <= ovf_q | (bus.pool_valid && (state_q != FILL));
    end
  end

  assign bus.f3_wr_en  = (state_q == FILL) && bus.pool_valid;
  assign bus.f3_waddr  = wcnt_q;
  assign bus.f3_raddr  = raddr_q;
  assign bus.rd_valid  = rdValid_q;
  assign bus.win_first = winFirst_q;
  assign bus.win_last  = winLast_q;
  assign bus.f3_busy   = (state_q == SCAN);
  assign bus.f3_done   = (state_q == DONE);
  assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_f3_ram_ctrl.sv
// Scoreboard bench for f3_ram_ctrl: drivers queue expected writes, issue
// addresses and return flags; a negedge monitor pops and compares them.
module tb_f3_ram_ctrl;
  localparam int AW    = 8;
  localparam int MAP_W = 14;
  localparam int K     = 5;
  localparam int OUT_W = MAP_W - K + 1;
  localparam int NREAD = OUT_W * OUT_W * K * K;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  int         wrQ[$];
  int         addrQ[$];
  logic [1:0] rdQ[$];

  int rdCount, firstCount, lastCount, doneCount, issueCount, lastIssueCycle;
  int issuedAddr[NREAD];

  f3_ram_ctrl_if #(.AW(AW)) bus ();

  f3_ram_ctrl #(.MAP_W(MAP_W), .K(K), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT presented output with nothing expected", name);
  endtask

  task automatic applyStimulus(input logic pv, input logic cr);
    bus.pool_valid = pv;
    bus.conv_ready = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".wr_en"},     bus.f3_wr_en,  0);
    checkOutput({tag, ".waddr"},     bus.f3_waddr,  0);
    checkOutput({tag, ".raddr"},     bus.f3_raddr,  0);
    checkOutput({tag, ".rd_valid"},  bus.rd_valid,  0);
    checkOutput({tag, ".win_first"}, bus.win_first, 0);
    checkOutput({tag, ".win_last"},  bus.win_last,  0);
    checkOutput({tag, ".busy"},      bus.f3_busy,   0);
    checkOutput({tag, ".done"},      bus.f3_done,   0);
    checkOutput({tag, ".ovf_err"},   bus.ovf_err,   0);
  endtask

  // Monitor: samples mid-cycle and consumes whatever the drivers queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.f3_wr_en) begin
        if (wrQ.size() == 0) unexpected("wr_en");
        else checkOutput("waddr", bus.f3_waddr, wrQ.pop_front());
      end
      if (bus.f3_busy && bus.conv_ready) begin
        if (addrQ.size() == 0) unexpected("issue");
        else checkOutput("raddr", bus.f3_raddr, addrQ.pop_front());
        if (issueCount < NREAD) issuedAddr[issueCount] = int'(bus.f3_raddr);
        issueCount++;
        lastIssueCycle = cycle;
      end
      if (bus.rd_valid) begin
        if (rdQ.size() == 0) unexpected("rd_valid");
        else checkOutput("winFlags", {bus.win_first, bus.win_last}, rdQ.pop_front());
        rdCount++;
        firstCount += int'(bus.win_first);
        lastCount  += int'(bus.win_last);
      end
      if (bus.f3_done) begin
        checkOutput("doneLatency", cycle, lastIssueCycle + 2);
        doneCount++;
      end
    end
  end

  // Fills 196 words; with gaps, every third cycle is left idle.
  task automatic fillImage(input bit gaps);
    int n = 0;
    int i = 0;
    while (n < MAP_W * MAP_W) begin
      if (gaps && (i % 3 == 2)) begin
        applyStimulus(1'b0, 1'b0);
      end else begin
        applyStimulus(1'b1, 1'b0);
        wrQ.push_back(n);
        n++;
        if (n == MAP_W * MAP_W) begin
          @(negedge clk);
          checkOutput("busyDuringLastWrite", bus.f3_busy, 0);
        end
      end
      step();
      i++;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("busyAfterFill", bus.f3_busy, 1);
    checkOutput("wrQueueDrained", wrQ.size(), 0);
  endtask

  task automatic runScan(input bit stall, input bit ovfPulse, input int abortAt);
    int refFirst10[10] = '{0, 1, 2, 3, 4, 14, 15, 16, 17, 18};
    rdCount = 0; firstCount = 0; lastCount = 0;
    doneCount = 0; issueCount = 0; lastIssueCycle = 0;
    for (int oy = 0; oy < OUT_W; oy++)
      for (int ox = 0; ox < OUT_W; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            addrQ.push_back((oy + ky) * MAP_W + ox + kx);
            rdQ.push_back({(ky == 0 && kx == 0), (ky == K - 1 && kx == K - 1)});
          end
    applyStimulus(1'b0, 1'b1);

    if (stall) begin
      repeat (8) step();
      applyStimulus(1'b0, 1'b0);
      checkOutput("stallIssueCount", issueCount, 8);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checkOutput("stallRaddr", bus.f3_raddr, 17);
        checkOutput("stallRdValid", bus.rd_valid, (k == 0) ? 1 : 0);
        step();
      end
      applyStimulus(1'b0, 1'b1);
    end

    if (ovfPulse) begin
      repeat (100) step();
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("ovfWrEn", bus.f3_wr_en, 0);
      step();
      applyStimulus(1'b0, 1'b1);
      checkOutput("ovfSticky", bus.ovf_err, 1);
    end

    if (abortAt > 0) begin
      for (int c = 0; c < 5000 && issueCount < abortAt; c++) step();
      if (issueCount < abortAt) unexpected("abortTimeout");
      checkOutput("ovfHeldNextImage", bus.ovf_err, 1);
      #2 rst = 1'b1;
      #1 checkAllZero("rstMid");
      applyStimulus(1'b0, 1'b0);
      addrQ.delete();
      rdQ.delete();
      wrQ.delete();
      repeat (2) step();
      rst = 1'b0;
      return;
    end

    for (int c = 0; c < 6000 && doneCount == 0; c++) step();
    applyStimulus(1'b0, 1'b0);
    if (doneCount == 0) unexpected("doneTimeout");
    step();
    checkOutput("doneCount", doneCount, 1);
    checkOutput("issueCount", issueCount, NREAD);
    checkOutput("rdValidCount", rdCount, NREAD);
    checkOutput("winFirstCount", firstCount, OUT_W * OUT_W);
    checkOutput("winLastCount", lastCount, OUT_W * OUT_W);
    checkOutput("addrQueueDrained", addrQ.size(), 0);
    checkOutput("rdQueueDrained", rdQ.size(), 0);
    for (int i = 0; i < 10; i++) checkOutput("firstTenAddr", issuedAddr[i], refFirst10[i]);
    checkOutput("window2Start", issuedAddr[25], 1);
    checkOutput("window11Start", issuedAddr[250], 14);
    checkOutput("finalAddr", issuedAddr[NREAD - 1], 195);
    checkOutput("busyAfterDone", bus.f3_busy, 0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 checkAllZero("rstInit");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] image A: gapped fill, scan with stall");
    fillImage(1'b1);
    runScan(1'b1, 1'b0, 0);
    checkOutput("ovfQuietA", bus.ovf_err, 0);

    $display("[TB] image B: overflow pulse during scan");
    fillImage(1'b0);
    runScan(1'b0, 1'b1, 0);
    checkOutput("ovfAfterB", bus.ovf_err, 1);

    $display("[TB] image C: reset after 700 reads");
    fillImage(1'b0);
    runScan(1'b0, 1'b0, 700);

    $display("[TB] images D and E back to back");
    fillImage(1'b0);
    runScan(1'b0, 1'b0, 0);
    fillImage(1'b0);
    runScan(1'b0, 1'b0, 0);
    checkOutput("ovfClearedByReset", bus.ovf_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
